grid_arbiter: RTL and testbench
===============================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 SHALL have parameter GRID_N, default 15: cells per grid side, giving a 15x15 grid of 2-bit cells (00 world, 01 food, 10 snake).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: denied cycles before the game/clear side is forced a slot.
REQ-003 SHALL have ports clk  in  1  (single clock, all logic on rising edge) and reset  in  1  (asynchronous, active-low).
REQ-004 SHALL have ports disp_req  in  1  (display read this cycle), disp_x  in  4, disp_y  in  4  (1-based cell coords).
REQ-005 SHALL have ports disp_valid  out  1 and disp_data  out  2  (display read result).
REQ-006 SHALL have ports game_valid  in  1, game_ready  out  1, game_we  in  1, game_x  in  4, game_y  in  4, game_wdata  in  2.
REQ-007 SHALL have ports game_rvalid  out  1 and game_rdata  out  2  (game read result).
REQ-008 SHALL have ports clear_start  in  1 (pulse) and clear_busy  out  1.
REQ-009 SHALL have memory-port outputs mem_en  1, mem_we  1, mem_addr  8, mem_wdata  2, and input mem_rdata  2; the RAM is single-port with synchronous 1-cycle read latency.

Function
REQ-010 SHALL compute address = (y-1)*GRID_N + (x-1), range 0..224; coords outside 1..GRID_N are out of range.
REQ-011 SHALL use states IDLE, WAIT (game op pending), and CLEAR (walking all addresses).
REQ-012 SHALL drive game_ready = 1 only in IDLE with clear_start low; a transfer occurs on game_valid && game_ready and latches op, address and data, then moves to WAIT.
REQ-013 SHALL grant the memory to the display whenever disp_req=1, unless starve_cnt == STARVE_LIMIT, in which case the WAIT/CLEAR access wins for that cycle.
REQ-014 SHALL, when the display is granted, set disp_valid=1 and disp_data=mem_rdata exactly one cycle later; if it is denied, disp_valid=0 in that following cycle.
REQ-015 SHALL, for an out-of-range display request, issue no memory access, and one cycle later give disp_valid=1 with disp_data=00.
REQ-016 SHALL issue the pending game op in WAIT on any cycle it is granted, then return to IDLE on the next edge.
REQ-017 SHALL, for a game read, pulse game_rvalid for one cycle, one cycle after issue, with game_rdata=mem_rdata.
REQ-018 SHALL, for an out-of-range game op, make no memory access and return to IDLE the next cycle; a read also gives game_rvalid=1 with data 00 one cycle later.
REQ-019 SHALL keep starve_cnt as a 4-bit saturating counter: increment on each denied WAIT/CLEAR cycle, clear on grant, and zero in IDLE.
REQ-020 SHALL, on clear_start in IDLE, enter CLEAR; a clear_start in WAIT is held and taken when WAIT exits.
REQ-021 SHALL, in CLEAR, write 00 to addresses 0..224 in ascending order, one per granted cycle, and return to IDLE after address 224.
REQ-022 SHALL hold clear_busy=1 throughout CLEAR and game_ready=0 throughout CLEAR.
REQ-023 SHALL ignore clear_start while already in CLEAR.
REQ-024 SHALL set mem_en=0 and mem_we=0 on cycles with no grant.

Reset
REQ-025 SHALL, on reset low, asynchronously force: state IDLE, starve_cnt 0, clear address 0, pending op dropped, any clear aborted.
REQ-026 SHALL, on reset low, drive all outputs to 0 except game_ready, which is 1 after reset releases.

Structure
REQ-027 SHALL place the state enum, cell codes (WORLD=00, FOOD=01, SNAKE=10), GRID_N and the address width in shared package grid_pkg.
REQ-028 SHALL use one natural sub-module, grid_addr (coords to address plus in-range flag), instantiated for the display and game paths.

Verification
REQ-029 SHALL verify display read: disp_req=1 at (1,1) with RAM[0]=10 -> mem_addr=0 same cycle, then disp_valid=1 and disp_data=10 next cycle.
REQ-030 SHALL verify write/read: game write (15,15)=01 with display idle -> mem_addr=224, mem_we=1; a following read returns game_rvalid=1 and game_rdata=01.
REQ-031 SHALL verify starvation: disp_req held 1 with a game write pending -> write issues on the 9th cycle, and disp_valid=0 on the following cycle.
REQ-032 SHALL verify clear: clear_start with display idle -> 225 writes of 00 on addresses 0..224, clear_busy high for 225 cycles, game_ready low throughout.
REQ-033 SHALL verify out-of-range: game read at (0,5) -> no mem_en, game_rvalid=1 and game_rdata=00 one cycle later.
REQ-034 SHALL verify reset mid-clear: reset low at address 100 -> clear_busy=0 immediately, and no further writes after release.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and constants for the snake-game grid memory arbiter.
// Cell codes, FSM states and grid geometry used by every grid_* module.
package grid_pkg;
    localparam int GRID_N = 15;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WORLD = 2'b00,
        FOOD  = 2'b01,
        SNAKE = 2'b10
    } cell_t;
endpackage

// File: rtl/grid_addr.sv
// Maps 1-based (x, y) cell coordinates to a linear RAM address and flags
// coordinates that fall outside the grid.
module grid_addr #(
    parameter int GRID_N = grid_pkg::GRID_N
) (
    input  logic [3:0]                  x,
    input  logic [3:0]                  y,
    output logic [grid_pkg::ADDR_W-1:0] addr,
    output logic                        in_range
);
    import grid_pkg::*;

    localparam logic [3:0]        SIDE   = 4'(GRID_N);
    localparam logic [ADDR_W-1:0] SIDE_W = ADDR_W'(GRID_N);

    logic [ADDR_W-1:0] x_w;
    logic [ADDR_W-1:0] y_w;

    assign x_w      = {4'd0, x};
    assign y_w      = {4'd0, y};
    assign in_range = (x != 4'd0) && (y != 4'd0) && (x <= SIDE) && (y <= SIDE);
    // Value is meaningless when in_range is low; callers gate on the flag.
    assign addr     = (y_w - 8'd1) * SIDE_W + (x_w - 8'd1);
endmodule

// File: rtl/grid_arbiter.sv
// Single-port grid RAM arbiter: display reads win by default, a pending game
// op or the clear walker is forced through after STARVE_LIMIT denied cycles.
module grid_arbiter #(
    parameter int GRID_N       = grid_pkg::GRID_N,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_req,
    input  logic [3:0] disp_x,
    input  logic [3:0] disp_y,
    output logic       disp_valid,
    output logic [1:0] disp_data,
    input  logic       game_valid,
    output logic       game_ready,
    input  logic       game_we,
    input  logic [3:0] game_x,
    input  logic [3:0] game_y,
    input  logic [1:0] game_wdata,
    output logic       game_rvalid,
    output logic [1:0] game_rdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);
    import grid_pkg::*;

    localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(GRID_N * GRID_N - 1);

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [ADDR_W-1:0] disp_addr, game_addr;
    logic              disp_inr, game_inr;

    grid_addr #(.GRID_N(GRID_N)) u_disp_addr (
        .x(disp_x), .y(disp_y), .addr(disp_addr), .in_range(disp_inr)
    );

    grid_addr #(.GRID_N(GRID_N)) u_game_addr (
        .x(game_x), .y(game_y), .addr(game_addr), .in_range(game_inr)
    );

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_hold_q, clr_hold_d;
    logic              pend_we_q, pend_we_d;
    logic              pend_inr_q, pend_inr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [1:0]        pend_wdata_q, pend_wdata_d;
    logic              disp_valid_q, disp_valid_d;
    logic              disp_rd_q, disp_rd_d;
    logic              game_rvalid_q, game_rvalid_d;
    logic              game_rd_q, game_rd_d;

    logic pend_want, disp_grant, pend_grant;

    always_comb begin
        pend_want  = ((state_q == WAIT) && pend_inr_q) || (state_q == CLEAR);
        disp_grant = disp_req && disp_inr && !(pend_want && (starve_q == STARVE_MAX));
        pend_grant = pend_want && !disp_grant;
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        clr_addr_d    = clr_addr_q;
        clr_hold_d    = clr_hold_q;
        pend_we_d     = pend_we_q;
        pend_inr_d    = pend_inr_q;
        pend_addr_d   = pend_addr_q;
        pend_wdata_d  = pend_wdata_q;
        // Out-of-range display reads complete immediately with WORLD data.
        disp_valid_d  = disp_req && (!disp_inr || disp_grant);
        disp_rd_d     = disp_grant;
        game_rvalid_d = 1'b0;
        game_rd_d     = 1'b0;

        case (state_q)
            IDLE: begin
                starve_d   = 4'd0;
                clr_hold_d = 1'b0;
                if (clear_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end else if (game_valid) begin
                    state_d      = WAIT;
                    pend_we_d    = game_we;
                    pend_inr_d   = game_inr;
                    pend_addr_d  = game_addr;
                    pend_wdata_d = game_wdata;
                end
            end
            WAIT: begin
                if (clear_start) clr_hold_d = 1'b1;
                if (!pend_inr_q || pend_grant) begin
                    game_rvalid_d = !pend_we_q;
                    game_rd_d     = pend_inr_q && !pend_we_q;
                    starve_d      = 4'd0;
                    clr_hold_d    = 1'b0;
                    clr_addr_d    = '0;
                    state_d       = (clr_hold_q || clear_start) ? CLEAR : IDLE;
                end else begin
                    starve_d = sat_inc(starve_q);
                end
            end
            CLEAR: begin
                if (pend_grant) begin
                    starve_d = 4'd0;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d    = IDLE;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end else begin
                    starve_d = sat_inc(starve_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            starve_q      <= 4'd0;
            clr_addr_q    <= '0;
            clr_hold_q    <= 1'b0;
            pend_we_q     <= 1'b0;
            pend_inr_q    <= 1'b0;
            disp_valid_q  <= 1'b0;
            disp_rd_q     <= 1'b0;
            game_rvalid_q <= 1'b0;
            game_rd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            clr_addr_q    <= clr_addr_d;
            clr_hold_q    <= clr_hold_d;
            pend_we_q     <= pend_we_d;
            pend_inr_q    <= pend_inr_d;
            disp_valid_q  <= disp_valid_d;
            disp_rd_q     <= disp_rd_d;
            game_rvalid_q <= game_rvalid_d;
            game_rd_q     <= game_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
    end

    // Memory port is combinational so the granted access hits the RAM this cycle.
    always_comb begin
        mem_en    = reset && (disp_grant || pend_grant);
        mem_we    = reset && pend_grant && ((state_q == CLEAR) || pend_we_q);
        mem_addr  = '0;
        mem_wdata = WORLD;
        if (reset && disp_grant) begin
            mem_addr = disp_addr;
        end else if (reset && pend_grant) begin
            mem_addr  = (state_q == CLEAR) ? clr_addr_q : pend_addr_q;
            mem_wdata = (state_q == CLEAR) ? WORLD : pend_wdata_q;
        end
    end

    assign disp_valid  = disp_valid_q;
    assign disp_data   = disp_rd_q ? mem_rdata : WORLD;
    assign game_rvalid = game_rvalid_q;
    assign game_rdata  = game_rd_q ? mem_rdata : WORLD;
    assign game_ready  = reset && (state_q == IDLE) && !clear_start;
    assign clear_busy  = (state_q == CLEAR);
endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter with a behavioural single-port RAM and
// queued expectations for display and game read results.
module tb_grid_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       disp_req;
    logic [3:0] disp_x, disp_y;
    logic       disp_valid;
    logic [1:0] disp_data;
    logic       game_valid, game_ready, game_we;
    logic [3:0] game_x, game_y;
    logic [1:0] game_wdata;
    logic       game_rvalid;
    logic [1:0] game_rdata;
    logic       clear_start, clear_busy;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    grid_arbiter dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .game_valid(game_valid), .game_ready(game_ready), .game_we(game_we),
        .game_x(game_x), .game_y(game_y), .game_wdata(game_wdata),
        .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [1:0] data;
        int         due;
    } exp_t;

    exp_t disp_q[$];
    exp_t game_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to the next falling edge and retire any result due this cycle.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        #1;
        cyc++;
        if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
            e = disp_q.pop_front();
            chk("disp_valid", disp_valid, 1);
            chk("disp_data", disp_data, e.data);
        end else if (disp_valid !== 1'b0) begin
            chk("disp_valid_unexpected", disp_valid, 0);
        end
        if (game_q.size() > 0 && game_q[0].due == cyc) begin
            e = game_q.pop_front();
            chk("game_rvalid", game_rvalid, 1);
            chk("game_rdata", game_rdata, e.data);
        end else if (game_rvalid !== 1'b0) begin
            chk("game_rvalid_unexpected", game_rvalid, 0);
        end
    endtask

    task automatic push_disp(input logic [1:0] d);
        disp_q.push_back('{data: d, due: cyc + 1});
    endtask

    task automatic push_game(input logic [1:0] d);
        game_q.push_back('{data: d, due: cyc + 1});
    endtask

    // Hands one op over in IDLE; returns in the first WAIT cycle, inputs settled.
    task automatic game_req(input logic we, input logic [3:0] x, input logic [3:0] y,
                            input logic [1:0] d);
        game_valid = 1'b1; game_we = we; game_x = x; game_y = y; game_wdata = d;
        #1;
        chk("game_ready_idle", game_ready, 1);
        tick();
        game_valid = 1'b0;
        #1;
    endtask

    task automatic disp_read(input logic [3:0] x, input logic [3:0] y,
                             input logic en, input logic [7:0] a, input logic [1:0] d);
        disp_req = 1'b1; disp_x = x; disp_y = y;
        #1;
        chk("disp_mem_en", mem_en, en);
        if (en) begin
            chk("disp_mem_we", mem_we, 0);
            chk("disp_mem_addr", mem_addr, a);
        end
        push_disp(d);
        tick();
        disp_req = 1'b0;
    endtask

    initial begin
        int writes;
        reset = 1'b0; disp_req = 1'b0; disp_x = '0; disp_y = '0;
        game_valid = 1'b0; game_we = 1'b0; game_x = '0; game_y = '0; game_wdata = '0;
        clear_start = 1'b0;
        #2;
        chk("rst_game_ready", game_ready, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_game_rvalid", game_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("post_rst_game_ready", game_ready, 1);
        chk("idle_mem_en", mem_en, 0);

        // Seed RAM[0] with SNAKE, then the display reads it back.
        game_req(1'b1, 4'd1, 4'd1, 2'b10);
        chk("wr11_en", mem_en, 1);
        chk("wr11_we", mem_we, 1);
        chk("wr11_addr", mem_addr, 0);
        chk("wr11_data", mem_wdata, 2'b10);
        tick();
        disp_read(4'd1, 4'd1, 1'b1, 8'd0, 2'b10);

        // Corner cell write then read through the game port.
        game_req(1'b1, 4'd15, 4'd15, 2'b01);
        chk("wr1515_we", mem_we, 1);
        chk("wr1515_addr", mem_addr, 224);
        chk("wr1515_data", mem_wdata, 2'b01);
        tick();
        game_req(1'b0, 4'd15, 4'd15, 2'b00);
        chk("rd1515_en", mem_en, 1);
        chk("rd1515_we", mem_we, 0);
        chk("rd1515_addr", mem_addr, 224);
        push_game(2'b01);
        tick();
        disp_read(4'd15, 4'd15, 1'b1, 8'd224, 2'b01);
        disp_read(4'd0, 4'd3, 1'b0, 8'd0, 2'b00);

        // Out-of-range game ops touch no memory.
        game_req(1'b0, 4'd0, 4'd5, 2'b00);
        chk("oor_rd_en", mem_en, 0);
        push_game(2'b00);
        tick();
        chk("oor_rd_ready", game_ready, 1);
        game_req(1'b1, 4'd16, 4'd1, 2'b11);
        chk("oor_wr_en", mem_en, 0);
        tick();

        // Starvation: display held busy, pending write must get through.
        disp_req = 1'b1; disp_x = 4'd1; disp_y = 4'd1;
        game_valid = 1'b1; game_we = 1'b1; game_x = 4'd2; game_y = 4'd1; game_wdata = 2'b01;
        #1;
        chk("starve_ready", game_ready, 1);
        push_disp(2'b10);
        tick();
        game_valid = 1'b0;
        #1;
        for (int i = 1; i <= 8; i++) begin
            chk("starve_disp_we", mem_we, 0);
            chk("starve_disp_addr", mem_addr, 0);
            push_disp(2'b10);
            tick();
        end
        chk("starve_wr_en", mem_en, 1);
        chk("starve_wr_we", mem_we, 1);
        chk("starve_wr_addr", mem_addr, 1);
        chk("starve_wr_data", mem_wdata, 2'b01);
        tick();
        chk("starve_denied_valid", disp_valid, 0);
        chk("starve_back_idle", game_ready, 1);
        push_disp(2'b10);
        tick();
        disp_req = 1'b0;
        game_req(1'b0, 4'd2, 4'd1, 2'b00);
        chk("starve_rd_addr", mem_addr, 1);
        push_game(2'b01);
        tick();

        // Full clear with the display idle.
        clear_start = 1'b1;
        #1;
        chk("clr_ready_start", game_ready, 0);
        tick();
        clear_start = 1'b0;
        #1;
        writes = 0;
        for (int i = 0; i < 225; i++) begin
            chk("clr_busy", clear_busy, 1);
            chk("clr_ready", game_ready, 0);
            chk("clr_addr", mem_addr, i);
            if (mem_en && mem_we && mem_wdata == 2'b00) writes++;
            tick();
        end
        chk("clr_writes", writes, 225);
        chk("clr_done_busy", clear_busy, 0);
        chk("clr_done_ready", game_ready, 1);
        chk("clr_done_en", mem_en, 0);
        game_req(1'b0, 4'd15, 4'd15, 2'b00);
        push_game(2'b00);
        tick();

        // Clear requested during WAIT, then aborted by reset at address 100.
        game_req(1'b1, 4'd15, 4'd15, 2'b10);
        tick();
        game_req(1'b1, 4'd3, 4'd3, 2'b01);
        chk("hold_wr_addr", mem_addr, 32);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        #1;
        chk("hold_busy", clear_busy, 1);
        chk("hold_addr0", mem_addr, 0);
        for (int i = 0; i < 100; i++) tick();
        chk("abort_at100", mem_addr, 100);
        reset = 1'b0;
        #1;
        chk("abort_busy", clear_busy, 0);
        chk("abort_en", mem_en, 0);
        chk("abort_we", mem_we, 0);
        tick();
        reset = 1'b1;
        writes = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_en) writes++;
            tick();
        end
        chk("abort_no_writes", writes, 0);
        chk("abort_idle_busy", clear_busy, 0);
        disp_read(4'd15, 4'd15, 1'b1, 8'd224, 2'b10);
        disp_read(4'd3, 4'd3, 1'b1, 8'd32, 2'b00);
        tick();

        chk("disp_q_empty", disp_q.size(), 0);
        chk("game_q_empty", game_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
